coupler_2_to_4: RTL and testbench

Width coupler between merger tree levels. It accepts the 2-record output words of a 2-wide merger and pairs consecutive words into 4-record words. It buffers those words in a show-ahead FIFO that a 4-wide merger reads through an empty/read interface. Its ready output tolerates the upstream merger's one-cycle-registered ready.

---
 rtl/coupler_2_to_4.sv | 145 ++++++++++++++
 tb/tb_coupler_2_to_4.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/coupler_2_to_4.sv
// coupler_2_to_4
//
// Width coupler between merger tree levels. Pairs consecutive 2-record
// words from a 2-wide merger into 4-record entries and buffers them in a
// show-ahead FIFO read by a 4-wide merger.
//
// Optional feature macro: COUPLER_TERM_FLUSH_EN
//   When defined, an all-zero word arriving while nothing is held is
//   pushed at once as an all-zero entry, so run boundaries stay aligned
//   to 4-record entries. When undefined, every two words are paired.
//
// Ports:
//   i_clk      clock, all state on rising edge
//   i_rst_n    asynchronous active-low reset
//   i_data     incoming 2-record word (2*DATA_WIDTH)
//   i_write    i_data valid this cycle
//   o_ready    space available; upstream samples it one cycle late
//   o_data     head FIFO entry, show-ahead (4*DATA_WIDTH)
//   o_empty    FIFO holds no entry
//   i_read     dequeue head entry
//   o_overrun  sticky: an entry was dropped because the FIFO was full

module coupler_2_to_4 #(
    parameter int DATA_WIDTH = 80,
    parameter int DEPTH      = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [2*DATA_WIDTH-1:0] i_data,
    input  logic                    i_write,
    output logic                    o_ready,
    output logic [4*DATA_WIDTH-1:0] o_data,
    output logic                    o_empty,
    input  logic                    i_read,
    output logic                    o_overrun
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [2*DATA_WIDTH-1:0] half;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_ptr;
    logic [AW:0]             count;
    logic [4*DATA_WIDTH-1:0] mem [DEPTH];

    logic                    term;
    logic                    capture;
    logic                    push_req;
    logic [4*DATA_WIDTH-1:0] push_data;
    logic                    rd_en;
    logic                    full;
    logic                    push_ok;

`ifdef COUPLER_TERM_FLUSH_EN
    assign term = (i_data == '0);
`else
    assign term = 1'b0;
`endif

    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_en = i_read && (count != '0);
    // The read is applied first, so a full FIFO being read accepts a push.
    assign push_ok = push_req && (!full || rd_en);

    // ---------------- assembler FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= LOW;
        else          state <= state_next;
    end

    // ---------------- assembler FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            LOW:  if (i_write && !term) state_next = HIGH;
            HIGH: if (i_write)          state_next = LOW;
            default:                    state_next = LOW;
        endcase
    end

    // ---------------- assembler FSM: outputs ----------------
    always_comb begin
        capture   = 1'b0;
        push_req  = 1'b0;
        push_data = '0;
        case (state)
            LOW: begin
                if (i_write) begin
                    if (term) push_req = 1'b1;   // flush a terminator as {0,0}
                    else      capture  = 1'b1;
                end
            end
            HIGH: begin
                if (i_write) begin
                    push_req  = 1'b1;
                    push_data = {i_data, half};  // held word goes in the low half
                end
            end
            default: ;
        endcase
    end

    // Half register: the first word of a pair.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     half <= '0;
        else if (capture) half <= i_data;
    end

    // Entry storage carries no reset; o_data is masked while empty.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (rd_en)   rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            case ({push_ok, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) o_overrun <= 1'b1;
        end
    end

    // Ready keeps two words of margin: after deassertion upstream can still
    // deliver two words, which complete at most one entry.
    assign o_ready = (count <= (AW+1)'(DEPTH-2));
    assign o_empty = (count == '0);
    assign o_data  = o_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_coupler_2_to_4.sv
// tb_coupler_2_to_4
//
// Bench for coupler_2_to_4: directed scenarios plus a randomized run, all
// checked each cycle against a queue-based reference model of the coupler.

module tb_coupler_2_to_4;

    localparam int DW    = 80;
    localparam int DEPTH = 16;
    localparam int WW    = 2*DW;
    localparam int CW    = 4*DW;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [WW-1:0] i_data = '0;
    logic          i_write = 1'b0;
    logic          o_ready;
    logic [CW-1:0] o_data;
    logic          o_empty;
    logic          i_read = 1'b0;
    logic          o_overrun;

    coupler_2_to_4 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_data    (i_data),
        .i_write   (i_write),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_empty   (o_empty),
        .i_read    (i_read),
        .o_overrun (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    logic [CW-1:0] q[$];
    logic          m_half_v;
    logic [WW-1:0] m_half;
    logic          m_ovr;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_half_v = 1'b0;
        m_half   = '0;
        m_ovr    = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic [WW-1:0] d, input logic r);
        logic          do_push;
        logic [CW-1:0] ent;
        do_push = 1'b0;
        ent     = '0;
        if (r && q.size() > 0) void'(q.pop_front());
        if (w) begin
            if (m_half_v) begin
                ent = {d, m_half};
                do_push = 1'b1;
                m_half_v = 1'b0;
`ifdef COUPLER_TERM_FLUSH_EN
            end else if (d == '0) begin
                ent = '0;
                do_push = 1'b1;
`endif
            end else begin
                m_half   = d;
                m_half_v = 1'b1;
            end
        end
        if (do_push) begin
            if (q.size() < DEPTH) q.push_back(ent);
            else                  m_ovr = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("empty",   CW'(o_empty),   CW'(q.size() == 0));
        chk("data",    o_data,         (q.size() > 0) ? q[0] : '0);
        chk("ready",   CW'(o_ready),   CW'(q.size() <= DEPTH-2));
        chk("overrun", CW'(o_overrun), CW'(m_ovr));
    endtask

    // One clock: inputs are applied just after an edge, taken at the next edge.
    task automatic cyc(input logic w, input logic [WW-1:0] d, input logic r);
        i_write = w;
        i_data  = d;
        i_read  = r;
        @(posedge i_clk); #1;
        model_step(w, d, r);
        i_write = 1'b0;
        i_read  = 1'b0;
        check_outputs();
    endtask

    function automatic logic [WW-1:0] rword();
        logic [WW-1:0] v;
        v = '0;
        for (int k = 0; k < WW; k += 32) v = (v << 32) | WW'($urandom);
        if (v == '0) v = WW'(1);
        return v;
    endfunction

    task automatic apply_reset();
        i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_empty", CW'(o_empty), CW'(1'b1));
        @(posedge i_clk); #1;
        chk("rst_empty_hold", CW'(o_empty), CW'(1'b1));
        i_rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int exp_n);
        int n;
        n = 0;
        for (int g = 0; g < 4*DEPTH && !o_empty; g++) begin
            cyc(1'b0, '0, 1'b1);
            n++;
        end
        chk(tag, CW'(n), CW'(exp_n));
    endtask

    initial begin
        logic [WW-1:0] a, b;
        logic          rdy_prev, cur;
        int            extra;

        model_reset();
        #1;
        chk("reset_data",    o_data,         '0);
        chk("reset_empty",   CW'(o_empty),   CW'(1'b1));
        chk("reset_ready",   CW'(o_ready),   CW'(1'b1));
        chk("reset_overrun", CW'(o_overrun), CW'(1'b0));
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // basic pairing
        cyc(1'b1, {DW'(1), DW'(2)}, 1'b0);
        chk("pair_empty_after_first", CW'(o_empty), CW'(1'b1));
        cyc(1'b1, {DW'(3), DW'(4)}, 1'b0);
        chk("pair_empty_after_second", CW'(o_empty), CW'(1'b0));
        chk("pair_data", o_data, {DW'(3), DW'(4), DW'(1), DW'(2)});
        drain("pair_drain", 1);

        // fill with an upstream that sees o_ready one cycle late
        extra    = 0;
        rdy_prev = o_ready;
        for (int c = 0; c < 2*DEPTH + 4; c++) begin
            cur = o_ready;
            if (rdy_prev && !cur) extra++;
            cyc(rdy_prev, rword(), 1'b0);
            rdy_prev = cur;
        end
        if (m_half_v) begin
            extra++;
            cyc(1'b1, rword(), 1'b0);
        end
        chk("fill_extra_words_le2", CW'(extra <= 2), CW'(1'b1));
        chk("fill_ready_low",       CW'(o_ready),    CW'(1'b0));
        chk("fill_no_overrun",      CW'(o_overrun),  CW'(1'b0));

        // full FIFO: push and read in the same cycle
        cyc(1'b1, rword(), 1'b0);
        cyc(1'b1, rword(), 1'b1);
        chk("rdpush_overrun", CW'(o_overrun), CW'(1'b0));
        drain("rdpush_drain", DEPTH);

        // full FIFO: push with no read drops the entry
        for (int c = 0; c < 2*DEPTH; c++) cyc(1'b1, rword(), 1'b0);
        cyc(1'b1, rword(), 1'b0);
        cyc(1'b1, rword(), 1'b0);
        chk("overrun_set", CW'(o_overrun), CW'(1'b1));
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("overrun_sticky", CW'(o_overrun), CW'(1'b1));
        drain("overrun_drain", DEPTH);
        chk("overrun_after_drain", CW'(o_overrun), CW'(1'b1));

        // reset mid-stream drops the held half
        cyc(1'b1, rword(), 1'b0);
        apply_reset();
        chk("reset_clears_overrun", CW'(o_overrun), CW'(1'b0));
        a = rword();
        b = rword();
        cyc(1'b1, a, 1'b0);
        cyc(1'b1, b, 1'b0);
        chk("post_reset_entry", o_data, {b, a});
        drain("post_reset_drain", 1);

        // terminator word in LOW
        a = rword();
        b = rword();
        cyc(1'b1, '0, 1'b0);
`ifdef COUPLER_TERM_FLUSH_EN
        chk("term_flush_entry", o_data, '0);
        chk("term_flush_empty", CW'(o_empty), CW'(1'b0));
        cyc(1'b1, a, 1'b0);
        cyc(1'b1, b, 1'b0);
        drain("term_drain", 2);
`else
        chk("term_no_flush_empty", CW'(o_empty), CW'(1'b1));
        cyc(1'b1, a, 1'b0);
        chk("term_pairs_with_a", o_data, {a, WW'(0)});
        cyc(1'b1, b, 1'b0);
        drain("term_drain", 1);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic w, r;
            logic [WW-1:0] d;
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0) || (c > 1500 && $urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 7) == 0) ? '0 : rword();
            cyc(w, d, r);
            if (c == 2000) apply_reset();
        end
        drain("final_drain", q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
